// File: rtl/park_space_release_pkg.sv
// Shared definitions for the parking occupancy block.
//  - default geometry (8 spaces, 3-bit park numbers)
//  - FSM state encoding and request opcode encoding
package park_pkg;

  localparam int NUM_SPACES_DEF = 8;
  localparam int ADDR_W_DEF     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic {
    OP_RELEASE = 1'b0,
    OP_OCCUPY  = 1'b1
  } op_e;

endpackage

// File: rtl/park_space_release_if.sv
// Request/status bundle between the gate/encoder side (master) and the
// occupancy block (slave).
//  master drives : release_valid/number, occupy_valid/number
//  slave drives  : ready, parking_capacity (1 = free), free_count, full,
//                  empty, done, err
interface park_space_release_if
  import park_pkg::*;
#(
  parameter int NUM_SPACES = NUM_SPACES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
);
  logic                  release_valid;
  logic [ADDR_W-1:0]     release_number;
  logic                  occupy_valid;
  logic [ADDR_W-1:0]     occupy_number;
  logic                  ready;
  logic [NUM_SPACES-1:0] parking_capacity;
  logic [ADDR_W:0]       free_count;
  logic                  full;
  logic                  empty;
  logic                  done;
  logic                  err;

  modport master (
    output release_valid, release_number, occupy_valid, occupy_number,
    input  ready, parking_capacity, free_count, full, empty, done, err
  );

  modport slave (
    input  release_valid, release_number, occupy_valid, occupy_number,
    output ready, parking_capacity, free_count, full, empty, done, err
  );
endinterface

// File: rtl/park_space_release_decoder.sv
// decoder_3x8: park number -> one-hot slot select, inverse of the 8x3 encoder.
//  en_i      : when low the output is all zeros
//  num_i     : park number
//  onehot_o  : one bit per space; zero if num_i is out of range
module decoder_3x8 #(
  parameter int NUM_SPACES = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  en_i,
  input  logic [ADDR_W-1:0]     num_i,
  output logic [NUM_SPACES-1:0] onehot_o
);
  for (genvar i = 0; i < NUM_SPACES; i++) begin : g_bit
    assign onehot_o[i] = en_i && (num_i == ADDR_W'(i));
  end
endmodule

// File: rtl/park_space_release.sv
// park_space_release: owns the parking occupancy vector and applies one
// occupy/release request per 3 cycles (IDLE -> CHECK -> COMMIT).
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : slave side of park_space_release_if (requests in,
//               occupancy vector / count / full / empty / done / err out)
// A request is accepted in IDLE (release wins over occupy), validated in
// CHECK, and applied in COMMIT; done/err pulse for one cycle after COMMIT.
module park_space_release
  import park_pkg::*;
#(
  parameter int NUM_SPACES = NUM_SPACES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  park_space_release_if.slave  bus
);
  localparam logic [ADDR_W:0] NS_CNT = (ADDR_W+1)'(NUM_SPACES);

  state_e                state_q;
  op_e                   op_q;
  logic [ADDR_W-1:0]     num_q;
  logic [NUM_SPACES-1:0] oh_q;
  logic                  bad_q;
  logic [NUM_SPACES-1:0] cap_q, cap_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic                  full_q, empty_q, done_q, err_q, ready_q;

  logic [NUM_SPACES-1:0] dec_oh;
  logic                  hit, range_bad, bad_d;

  // Decoder only enabled in CHECK so its output is quiet otherwise.
  decoder_3x8 #(.NUM_SPACES(NUM_SPACES), .ADDR_W(ADDR_W)) u_dec (
    .en_i     (state_q == CHECK),
    .num_i    (num_q),
    .onehot_o (dec_oh)
  );

  // hit = selected slot is currently free. Out-of-range numbers decode to
  // zero, so they need an explicit range flag for the release case.
  always_comb begin
    hit       = |(dec_oh & cap_q);
    range_bad = {1'b0, num_q} >= NS_CNT;
    bad_d     = range_bad | ((op_q == OP_RELEASE) ? hit : ~hit);
  end

  // Vector/count update; only applied on a good commit, so the count can
  // never wrap (release needs an occupied slot, occupy a free one).
  always_comb begin
    cap_d = cap_q;
    cnt_d = cnt_q;
    if (op_q == OP_RELEASE) begin
      cap_d = cap_q | oh_q;
      cnt_d = cnt_q + 1'b1;
    end else begin
      cap_d = cap_q & ~oh_q;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_RELEASE;
      num_q   <= '0;
      oh_q    <= '0;
      bad_q   <= 1'b0;
      cap_q   <= '1;
      cnt_q   <= NS_CNT;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.release_valid) begin
            op_q    <= OP_RELEASE;
            num_q   <= bus.release_number;
            state_q <= CHECK;
            ready_q <= 1'b0;
          end else if (bus.occupy_valid) begin
            op_q    <= OP_OCCUPY;
            num_q   <= bus.occupy_number;
            state_q <= CHECK;
            ready_q <= 1'b0;
          end
        end
        CHECK: begin
          oh_q    <= dec_oh;
          bad_q   <= bad_d;
          state_q <= COMMIT;
        end
        COMMIT: begin
          if (bad_q) begin
            err_q <= 1'b1;
          end else begin
            done_q  <= 1'b1;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == '0);
            empty_q <= (cnt_d == NS_CNT);
          end
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready            = ready_q;
  assign bus.parking_capacity = cap_q;
  assign bus.free_count       = cnt_q;
  assign bus.full             = full_q;
  assign bus.empty            = empty_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;

endmodule
